// File: rtl/timer.sv
// -----------------------------------------------------------------------------
// timer -- grant-duration limiter for one port of an arbiter.
//
// Sits between a single requester and one arbiter port. Request, grant and
// acknowledge pass straight through (zero latency) while the port is ACTIVE.
// Consecutive granted cycles are counted; when TIMEOUT of them have elapsed
// the downstream request is forcibly withdrawn for HOLDOFF cycles (HOLD) so
// that other arbiter ports get a chance to win.
//
// Parameters:
//   TIMEOUT  maximum consecutive cycles up_grant may stay high (>= 1)
//   HOLDOFF  cycles down_req is forced low after expiry (>= 1)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset; also gates all outputs low
//   up_req      request from the requester
//   up_grant    grant returned to the requester
//   up_ack      requester's per-transfer acknowledge
//   down_req    request presented to the arbiter port
//   down_grant  grant from the arbiter port
//   down_ack    acknowledge forwarded to the arbiter
//   expired     one-cycle pulse on the ACTIVE->HOLD transition
//               (present only when TIMER_EXPIRE_OUT_EN is defined)
//
// Optional feature macro: TIMER_EXPIRE_OUT_EN
// -----------------------------------------------------------------------------
module timer #(
    parameter int TIMEOUT = 10,
    parameter int HOLDOFF = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic up_req,
    output logic up_grant,
    input  logic up_ack,
    output logic down_req,
    input  logic down_grant,
    output logic down_ack
`ifdef TIMER_EXPIRE_OUT_EN
    ,
    output logic expired
`endif
);

    localparam int MAX_CNT = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] HO_LAST   = CW'(HOLDOFF - 1);

    typedef enum logic [0:0] {
        ACTIVE = 1'b0,
        HOLD   = 1'b1
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   next_cnt_s;

    logic            fwd_req_s;
    logic            fwd_grant_s;
    logic            fwd_ack_s;
    logic            expire_s;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ACTIVE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
        end
    end

    // Next-state, counter update and pass-through path selection.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        fwd_req_s    = 1'b0;
        fwd_grant_s  = 1'b0;
        fwd_ack_s    = 1'b0;
        expire_s     = 1'b0;

        case (state_r)
            ACTIVE: begin
                fwd_req_s   = up_req;
                // A grant without our request is an arbiter contract breach
                // and is deliberately not passed upstream.
                fwd_grant_s = down_grant & up_req;
                fwd_ack_s   = up_ack & fwd_grant_s;
                if (fwd_grant_s) begin
                    if (cnt_r == TO_LAST) begin
                        next_state_s = HOLD;
                        next_cnt_s   = CNT_ZERO;
                        expire_s     = 1'b1;
                    end else begin
                        next_cnt_s   = cnt_r + CNT_ONE;
                    end
                end else begin
                    // Any gap in the grant restarts the tenure.
                    next_cnt_s = CNT_ZERO;
                end
            end
            HOLD: begin
                if (cnt_r == HO_LAST) begin
                    next_state_s = ACTIVE;
                    next_cnt_s   = CNT_ZERO;
                end else begin
                    next_cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                next_state_s = ACTIVE;
                next_cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Outputs are forced low while reset is held, independent of state.
    assign down_req = rst & fwd_req_s;
    assign up_grant = rst & fwd_grant_s;
    assign down_ack = rst & fwd_ack_s;

`ifdef TIMER_EXPIRE_OUT_EN
    assign expired  = rst & expire_s;
`endif

endmodule

// File: tb/tb_timer.sv
module tb_timer;

    localparam int TIMEOUT = 10;
    localparam int HOLDOFF = 1;

    logic clk = 1'b0;
    logic rst;
    logic up_req;
    logic up_ack;
    logic up_grant;
    logic down_req;
    logic down_grant;
    logic down_ack;
`ifdef TIMER_EXPIRE_OUT_EN
    logic expired;
`endif

    assign down_grant = down_req;

    always #5 clk = ~clk;

    timer #(
        .TIMEOUT(TIMEOUT),
        .HOLDOFF(HOLDOFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .up_req    (up_req),
        .up_grant  (up_grant),
        .up_ack    (up_ack),
        .down_req  (down_req),
        .down_grant(down_grant),
        .down_ack  (down_ack)
`ifdef TIMER_EXPIRE_OUT_EN
        ,
        .expired   (expired)
`endif
    );

    typedef struct {
        string name;
        logic  rst;
        logic  req;
        logic  ack;
        int    n;
        int    exp_gnt;
        int    exp_ack;
        int    exp_pulse;
    } seg_t;

    typedef struct {
        logic dreq;
        logic gnt;
        logic dack;
        logic exp;
    } out_t;

    out_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    bit   m_hold  = 1'b0;
    int   m_run   = 0;
    int   m_hleft = 0;
    int   run_len = 0;
    int   max_run = 0;

    function automatic out_t model_out();
        out_t o;
        o.dreq = 1'b0; o.gnt = 1'b0; o.dack = 1'b0; o.exp = 1'b0;
        if (rst && !m_hold) begin
            o.dreq = up_req;
            o.gnt  = up_req;
            o.dack = up_ack & up_req;
            o.exp  = up_req && (m_run == TIMEOUT - 1);
        end
        return o;
    endfunction

    task automatic model_step();
        out_t o;
        o = model_out();
        if (!rst) begin
            m_hold = 1'b0;
            m_run  = 0;
        end else if (m_hold) begin
            m_hleft = m_hleft - 1;
            if (m_hleft == 0) m_hold = 1'b0;
        end else if (o.gnt) begin
            m_run = m_run + 1;
            if (m_run == TIMEOUT) begin
                m_hold  = 1'b1;
                m_hleft = HOLDOFF;
                m_run   = 0;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic check_bit(string nm, logic act, logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", nm, act, req, $time);
        end
    endtask

    task automatic check_int(string nm, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic run_seg(seg_t s);
        int   gcnt = 0;
        int   acnt = 0;
        int   pcnt = 0;
        out_t e;
        for (int i = 0; i < s.n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            rst    = s.rst;
            up_req = s.req;
            up_ack = s.ack;
            sb.push_back(model_out());
            @(negedge clk);
            e = sb.pop_front();
            check_bit({s.name, ".down_req"}, down_req, e.dreq);
            check_bit({s.name, ".up_grant"}, up_grant, e.gnt);
            check_bit({s.name, ".down_ack"}, down_ack, e.dack);
`ifdef TIMER_EXPIRE_OUT_EN
            check_bit({s.name, ".expired"}, expired, e.exp);
            if (expired === 1'b1) pcnt++;
`endif
            if (up_grant === 1'b1) begin
                gcnt++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (down_ack === 1'b1) acnt++;
        end
        check_int({s.name, ".grant_cycles"}, gcnt, s.exp_gnt);
        check_int({s.name, ".ack_cycles"}, acnt, s.exp_ack);
`ifdef TIMER_EXPIRE_OUT_EN
        check_int({s.name, ".expiry_pulses"}, pcnt, s.exp_pulse);
`endif
    endtask

    seg_t segs[$];

    initial begin
        rst    = 1'b0;
        up_req = 1'b1;
        up_ack = 1'b0;

        //                name        rst   req   ack   n   gnt ack pulse
        segs.push_back('{"reset",     1'b0, 1'b1, 1'b0, 10, 0,  0,  0});
        segs.push_back('{"short",     1'b1, 1'b1, 1'b0, 5,  5,  0,  0});
        segs.push_back('{"idle1",     1'b1, 1'b0, 1'b0, 15, 0,  0,  0});
        segs.push_back('{"long",      1'b1, 1'b1, 1'b0, 15, 14, 0,  1});
        segs.push_back('{"idle2",     1'b1, 1'b0, 1'b0, 5,  0,  0,  0});
        segs.push_back('{"gap_a",     1'b1, 1'b1, 1'b0, 8,  8,  0,  0});
        segs.push_back('{"gap_b",     1'b1, 1'b0, 1'b0, 1,  0,  0,  0});
        segs.push_back('{"gap_c",     1'b1, 1'b1, 1'b0, 8,  8,  0,  0});
        segs.push_back('{"idle3",     1'b1, 1'b0, 1'b0, 3,  0,  0,  0});
        segs.push_back('{"ack",       1'b1, 1'b1, 1'b1, 12, 11, 11, 1});
        segs.push_back('{"idle4",     1'b1, 1'b0, 1'b1, 4,  0,  0,  0});
        segs.push_back('{"pre_hold",  1'b1, 1'b1, 1'b0, 10, 10, 0,  1});
        segs.push_back('{"rst_hold",  1'b0, 1'b1, 1'b0, 2,  0,  0,  0});
        segs.push_back('{"post_rst",  1'b1, 1'b1, 1'b0, 10, 10, 0,  1});
        segs.push_back('{"post_hold", 1'b1, 1'b1, 1'b1, 1,  0,  0,  0});
        segs.push_back('{"resume",    1'b1, 1'b1, 1'b0, 3,  3,  0,  0});

        foreach (segs[k]) run_seg(segs[k]);

        // Tenure bound across the whole run: the longest grant run must
        // reach, but never exceed, TIMEOUT.
        check_int("max_tenure", max_run, TIMEOUT);
        check_int("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer.md
# timer

Grant-duration limiter inserted between one requester and one arbiter port. Passes the requester's request downstream and the arbiter's grant upstream. Counts consecutive granted cycles and, once TIMEOUT is reached, forcibly withdraws the downstream request for a hold-off period so other arbiter ports can win. Used on each port of a round-robin arbiter to bound the tenure of any single master.

## Interface
- TIMEOUT, 10, maximum consecutive cycles up_grant may stay high; integer ≥ 1.
- HOLDOFF, 1, cycles down_req is forced low after expiry; integer ≥ 1.
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low; one clock, reset is asynchronous and active-low.
- up_req  in  1  request from the requester.
- up_grant  out  1  grant returned to the requester.
- up_ack  in  1  requester's per-transfer acknowledge, valid only while granted.
- down_req  out  1  request presented to the arbiter port.
- down_grant  in  1  grant from the arbiter port.
- down_ack  out  1  acknowledge forwarded to the arbiter.
- expired  out  1  only with TIMER_EXPIRE_OUT_EN; one-cycle expiry pulse.

## Operation
- States:
  - ACTIVE: pass-through and counting.
  - HOLD: forced release.
- Counter cnt, width $clog2(max(TIMEOUT,HOLDOFF)+1), unsigned, saturates only by state change; never wraps.
- ACTIVE outputs:
  - down_req = up_req.
  - up_grant = down_grant & up_req.
  - down_ack = up_ack & up_grant.
- HOLD outputs: down_req = 0, up_grant = 0, down_ack = 0; up_req and down_grant ignored.
- ACTIVE, up_grant=1, cnt < TIMEOUT-1: cnt += 1.
- ACTIVE, up_grant=1, cnt == TIMEOUT-1: go HOLD, cnt = 0.
- ACTIVE, up_grant=0: cnt = 0; a grant gap or request drop restarts tenure.
- HOLD, cnt < HOLDOFF-1: cnt += 1.
- HOLD, cnt == HOLDOFF-1: go ACTIVE, cnt = 0.
- up_ack has no effect on counting.
- Arbiter contract: a grant asserted without down_req is ignored (up_grant stays 0).

## Timing
- Reset asserted (rst=0):
  - state = ACTIVE, cnt = 0.
  - down_req, up_grant, down_ack, expired all forced 0 combinationally.
- Reset deasserts synchronously in effect: first counting edge is the first rising edge with rst=1.
- Reset mid-tenure or mid-HOLD: immediate return to ACTIVE with cnt = 0.
- Zero-latency paths:
  - up_req to down_req.
  - down_grant to up_grant.
  - up_ack to down_ack.
- Tenure limit: up_grant is high for at most TIMEOUT consecutive cycles.
- After expiry: down_req and up_grant are low for exactly HOLDOFF cycles.
- If up_req is still high after HOLDOFF, down_req reasserts on the first ACTIVE cycle.
- up_req dropped on the same edge as expiry: HOLD still entered.
- TIMEOUT=1: grant lasts one cycle, then HOLD.

## Configuration
- TIMER_EXPIRE_OUT_EN defined:
  - adds output port expired, 1 bit.
  - expired is high for exactly the one cycle in which the ACTIVE→HOLD transition is taken (cnt == TIMEOUT-1 & up_grant).
  - reset value 0.
- Undefined: no expired port; all other behaviour identical.

## Test plan
All cases use TIMEOUT=10, HOLDOFF=1, down_grant tied to down_req.
- Reset: hold rst=0 for 10 cycles with up_req=1 -> down_req=0, up_grant=0 throughout; release -> down_req=1, up_grant=1 same cycle.
- Short burst: up_req=1 for 5 cycles, then 0 for 15 -> up_grant high 5 cycles, no HOLD, cnt back to 0.
- Long burst: up_req=1 for 15 cycles -> up_grant high 10 cycles, low 1 cycle, high 4 more cycles; expired pulses once (macro on).
- Gap restart: up_req high 8 cycles, low 1, high 8 -> no HOLD entered.
- Ack forwarding: up_ack=1 while granted -> down_ack=1; up_ack=1 during HOLD -> down_ack=0.
- Reset mid-HOLD: assert rst=0 during HOLD, release with up_req=1 -> immediate grant, full 10-cycle tenure.
